hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage RV32I core.
- Generates the enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three cases: load-use stalls, control-transfer flushes resolved in EX, and multi-cycle data-memory waits.
- Also holds the pipeline for a programmable warm-up period after reset.

---
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use
// stalls, EX redirects, data-memory waits and post-reset hold. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned RST_HOLD = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic       use_rs1_D,
    input  logic       use_rs2_D,
    input  logic [4:0] Rd_E,
    input  logic       MemRead_E,
    input  logic       redirect_E,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] loaduse_events
`endif
);

    localparam int unsigned HOLD_W    = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam int unsigned HOLD_LAST = (RST_HOLD > 0) ? RST_HOLD - 1 : 0;

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam state_t RST_STATE = (RST_HOLD == 0) ? S_RUN : S_HOLD;

    state_t              r_state;
    state_t              w_next_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_next;
    logic                w_mem_stall;
    logic                w_load_use;
    logic                w_release;
    logic                w_stall_evt;
    logic                w_redirect_evt;
    logic                w_loaduse_evt;

    assign w_mem_stall = dmem_req_M && !dmem_ready;
    assign w_load_use  = MemRead_E && (Rd_E != 5'd0) &&
                         ((use_rs1_D && (rs1_D == Rd_E)) ||
                          (use_rs2_D && (rs2_D == Rd_E)));

    // State and hold-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next state and pipeline controls; reset overrides everything at the end
    always_comb begin
        w_next_state    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        pc_en           = 1'b0;
        if_id_en        = 1'b0;
        id_ex_en        = 1'b0;
        ex_mem_en       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        busy            = 1'b0;
        w_release       = 1'b0;
        w_stall_evt     = 1'b0;
        w_redirect_evt  = 1'b0;
        w_loaduse_evt   = 1'b0;

        case (r_state)
            S_HOLD: begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                busy        = 1'b1;
                if (r_hold_cnt == HOLD_W'(HOLD_LAST)) begin
                    w_next_state    = S_RUN;
                    w_hold_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (w_mem_stall) begin
                    busy         = 1'b1;
                    w_next_state = S_MEM_WAIT;
                end else begin
                    w_release = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_release    = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    busy = 1'b1;
                end
            end
            default: begin
                w_next_state = S_HOLD;
            end
        endcase

        // Redirect outranks load-use: the decode instruction is on the wrong path
        if (w_release) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            if (redirect_E) begin
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                w_redirect_evt = 1'b1;
            end else if (w_load_use) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_flush   = 1'b1;
                w_loaduse_evt = 1'b1;
            end
        end

        w_stall_evt = ((r_state == S_RUN) || (r_state == S_MEM_WAIT)) && !pc_en;

        if (rst) begin
            pc_en           = 1'b0;
            if_id_en        = 1'b0;
            id_ex_en        = 1'b0;
            ex_mem_en       = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            busy            = 1'b1;
            w_stall_evt     = 1'b0;
            w_redirect_evt  = 1'b0;
            w_loaduse_evt   = 1'b0;
            w_next_state    = RST_STATE;
            w_hold_cnt_next = '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
    logic [CNT_W-1:0] r_loaduse_events;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles   <= '0;
            r_flush_events   <= '0;
            r_loaduse_events <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_redirect_evt && (r_flush_events != '1))
                r_flush_events <= r_flush_events + CNT_W'(1);
            if (w_loaduse_evt && (r_loaduse_events != '1))
                r_loaduse_events <= r_loaduse_events + CNT_W'(1);
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign flush_events   = r_flush_events;
    assign loaduse_events = r_loaduse_events;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a cycle-count based behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned TB_HOLD  = 2;
    localparam int unsigned TB_CNT_W = 32;

    localparam logic [6:0] E_RST  = 7'b0000111;
    localparam logic [6:0] E_HOLD = 7'b0011111;
    localparam logic [6:0] E_RUN  = 7'b1111000;
    localparam logic [6:0] E_LU   = 7'b0011010;
    localparam logic [6:0] E_RDIR = 7'b1111110;
    localparam logic [6:0] E_MEMW = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_D, rs2_D, Rd_E;
    logic       use_rs1_D, use_rs2_D, MemRead_E, redirect_E, dmem_req_M, dmem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cycles, flush_events, loaduse_events;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RST_HOLD(TB_HOLD), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .Rd_E(Rd_E), .MemRead_E(MemRead_E), .redirect_E(redirect_E),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events),
        .loaduse_events(loaduse_events)
`endif
    );

    logic [6:0] act;
    assign act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, busy};

    // Model: cycles since reset release, whether a memory wait is outstanding, event tallies
    bit m_valid = 1'b0;
    int m_since;
    bit m_waiting;
    int m_stall, m_flush, m_lu;

    function automatic bit f_loaduse();
        return MemRead_E && (Rd_E != 5'd0) &&
               ((use_rs1_D && (rs1_D == Rd_E)) || (use_rs2_D && (rs2_D == Rd_E)));
    endfunction

    function automatic bit f_mem_stall();
        if (m_waiting) return !dmem_ready;
        return dmem_req_M && !dmem_ready;
    endfunction

    function automatic logic [6:0] f_expect();
        if (rst)                       return E_RST;
        if (m_since < int'(TB_HOLD))   return E_HOLD;
        if (f_mem_stall())             return E_MEMW;
        if (redirect_E)                return E_RDIR;
        if (f_loaduse())               return E_LU;
        return E_RUN;
    endfunction

    always @(posedge clk) begin
        logic [6:0] e;
        bit         post;
        e    = f_expect();
        post = (m_since >= int'(TB_HOLD));
        if (rst) begin
            m_valid   <= 1'b1;
            m_since   <= 0;
            m_waiting <= 1'b0;
            m_stall   <= 0;
            m_flush   <= 0;
            m_lu      <= 0;
        end else if (m_valid) begin
            if (!post) m_since <= m_since + 1;
            m_waiting <= post && f_mem_stall();
            if (post && !e[6]) m_stall <= m_stall + 1;
            if (post && !f_mem_stall() && redirect_E) m_flush <= m_flush + 1;
            if (post && !f_mem_stall() && !redirect_E && f_loaduse()) m_lu <= m_lu + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (act !== f_expect()) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, act, f_expect());
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if ({stall_cycles, flush_events, loaduse_events} !==
                {TB_CNT_W'(m_stall), TB_CNT_W'(m_flush), TB_CNT_W'(m_lu)}) begin
                failures++;
                $display("FAIL model_cnt t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                         stall_cycles, flush_events, loaduse_events, m_stall, m_flush, m_lu);
            end
`endif
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                          input bit u2, input logic [4:0] rd, input bit mr, input bit rdir,
                          input bit req, input bit rdy);
        rs1_D = rs1; rs2_D = rs2; use_rs1_D = u1; use_rs2_D = u2; Rd_E = rd;
        MemRead_E = mr; redirect_E = rdir; dmem_req_M = req; dmem_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_check(input string name, input logic [6:0] exp);
        @(negedge clk);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic cnt_check(input string name, input int s, input int f, input int l);
        @(negedge clk);
        checks++;
        if ({stall_cycles, flush_events, loaduse_events} !==
            {TB_CNT_W'(s), TB_CNT_W'(f), TB_CNT_W'(l)}) begin
            failures++;
            $display("FAIL %s got=%0d/%0d/%0d exp=%0d/%0d/%0d", name,
                     stall_cycles, flush_events, loaduse_events, s, f, l);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc();
        cyc();
        cyc_check("reset", E_RST);
        rst = 1'b0;
        cyc_check("hold0", E_HOLD);
        cyc_check("hold1", E_HOLD);
        cyc_check("run_after_hold", E_RUN);

        set_in(5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 0, 0);
        cyc_check("loaduse_rs1", E_LU);
        set_in(5'd5, 5'd1, 1, 0, 5'd5, 0, 0, 0, 0);
        cyc_check("after_loaduse", E_RUN);
        set_in(5'd7, 5'd9, 0, 1, 5'd9, 1, 0, 0, 0);
        cyc_check("loaduse_rs2", E_LU);
        set_in(5'd7, 5'd9, 1, 0, 5'd9, 1, 0, 0, 0);
        cyc_check("rs2_unused", E_RUN);
        set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
        cyc_check("rd_zero", E_RUN);
        set_in(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0);
        cyc_check("redirect_over_lu", E_RDIR);
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc_check("after_redirect", E_RUN);

        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc_check("mem_wait", E_MEMW);
        dmem_ready = 1'b1;
        cyc_check("mem_release_redirect", E_RDIR);
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        cyc_check("after_release", E_RUN);
        dmem_ready = 1'b1;
        cyc_check("ready_without_req", E_RUN);

        set_in(5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 1, 0);
        cyc_check("mem_wait_lu0", E_MEMW);
        cyc_check("mem_wait_lu1", E_MEMW);
        dmem_ready = 1'b1;
        cyc_check("mem_release_lu", E_LU);
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        cnt_check("counters_mid", 8, 2, 3);
`endif
        cyc_check("after_release_lu", E_RUN);

        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        cyc_check("wait_before_rst0", E_MEMW);
        cyc_check("wait_before_rst1", E_MEMW);
        rst = 1'b1;
        cyc_check("rst_mid_wait", E_RST);
        rst = 1'b0;
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        cnt_check("counters_cleared", 0, 0, 0);
`endif
        cyc_check("hold_after_abort0", E_HOLD);
        cyc_check("hold_after_abort1", E_HOLD);
        cyc_check("run_after_abort", E_RUN);

        // Mixed traffic checked by the model each cycle
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
